// File: rtl/event_rate_monitor_if.sv
// Bundle of control, event and snapshot signals for event_rate_monitor.
// master drives windows and events; slave is the monitor itself.
interface event_rate_monitor_if #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int WW  = 16
);
    logic                enable;
    logic                clear;
    logic [WW-1:0]       win_len;
    logic [CW-1:0]       thresh;
    logic [NCH-1:0]      ev;
    logic                busy;
    logic [WW-1:0]       win_count;
    logic                snap_valid;
    logic [NCH*CW-1:0]   snap_count;
    logic [NCH-1:0]      over;
    logic [NCH-1:0]      sat;

    modport master (
        output enable, clear, win_len, thresh, ev,
        input  busy, win_count, snap_valid, snap_count, over, sat
    );

    modport slave (
        input  enable, clear, win_len, thresh, ev,
        output busy, win_count, snap_valid, snap_count, over, sat
    );
endinterface

// File: rtl/event_rate_monitor.sv
// Per-channel windowed event counter with saturation, threshold flags and
// a snapshot of each completed window.
module event_rate_monitor #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int WW  = 16
) (
    input  logic                  clk,
    input  logic                  reset_l,
    event_rate_monitor_if.slave   bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] W_ONE = {{(WW-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [WW-1:0]           len_r, len_s, wcnt_r, wcnt_s;
    logic [NCH-1:0][CW-1:0]  cnt_r, cnt_s, upd_s, snap_r, snap_s;
    logic [NCH-1:0]          csat_r, csat_s, usat_s;
    logic [NCH-1:0]          over_r, over_s, sat_r, sat_s;
    logic                    sv_r, sv_s;
    logic                    last_s, start_s;

    // Saturating per-channel increment including this cycle's events
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.ev[i] && (cnt_r[i] != C_MAX)) begin
                upd_s[i] = cnt_r[i] + C_ONE;
            end else begin
                upd_s[i] = cnt_r[i];
            end
            usat_s[i] = csat_r[i] | (upd_s[i] == C_MAX);
        end
    end

    assign last_s  = (state_r == RUN) && (wcnt_r == (len_r - W_ONE));
    assign start_s = bus.enable && (bus.win_len != {WW{1'b0}});

    // Next-state, window bookkeeping and snapshot capture
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        wcnt_s  = wcnt_r;
        cnt_s   = cnt_r;
        csat_s  = csat_r;
        snap_s  = snap_r;
        over_s  = over_r;
        sat_s   = sat_r;
        sv_s    = 1'b0;
        if (bus.clear) begin
            state_s = IDLE;
            len_s   = {WW{1'b0}};
            wcnt_s  = {WW{1'b0}};
            cnt_s   = '0;
            csat_s  = {NCH{1'b0}};
            snap_s  = '0;
            over_s  = {NCH{1'b0}};
            sat_s   = {NCH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    wcnt_s = {WW{1'b0}};
                    cnt_s  = '0;
                    csat_s = {NCH{1'b0}};
                    if (start_s) begin
                        state_s = RUN;
                        len_s   = bus.win_len;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        snap_s = upd_s;
                        sat_s  = usat_s;
                        for (int i = 0; i < NCH; i++) begin
                            over_s[i] = (upd_s[i] >= bus.thresh);
                        end
                        sv_s   = 1'b1;
                        wcnt_s = {WW{1'b0}};
                        cnt_s  = '0;
                        csat_s = {NCH{1'b0}};
                        if (start_s) begin
                            state_s = RUN;
                            len_s   = bus.win_len;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (!bus.enable) begin
                        // Abort: partial counts are dropped, snapshot untouched
                        state_s = IDLE;
                        wcnt_s  = {WW{1'b0}};
                        cnt_s   = '0;
                        csat_s  = {NCH{1'b0}};
                    end else begin
                        wcnt_s = wcnt_r + W_ONE;
                        cnt_s  = upd_s;
                        csat_s = usat_s;
                    end
                end
                default: begin
                    state_s = IDLE;
                    wcnt_s  = {WW{1'b0}};
                    cnt_s   = '0;
                    csat_s  = {NCH{1'b0}};
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_r <= IDLE;
            len_r   <= {WW{1'b0}};
            wcnt_r  <= {WW{1'b0}};
            cnt_r   <= '0;
            csat_r  <= {NCH{1'b0}};
            snap_r  <= '0;
            over_r  <= {NCH{1'b0}};
            sat_r   <= {NCH{1'b0}};
            sv_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            wcnt_r  <= wcnt_s;
            cnt_r   <= cnt_s;
            csat_r  <= csat_s;
            snap_r  <= snap_s;
            over_r  <= over_s;
            sat_r   <= sat_s;
            sv_r    <= sv_s;
        end
    end

    assign bus.busy       = (state_r == RUN);
    assign bus.win_count  = wcnt_r;
    assign bus.snap_valid = sv_r;
    assign bus.snap_count = snap_r;
    assign bus.over       = over_r;
    assign bus.sat        = sat_r;
endmodule

// File: doc/event_rate_monitor.md
EVENT_RATE_MONITOR -- requirements
Module: event_rate_monitor

Interface
REQ-001 The module SHALL have parameter NCH, default 4, meaning the number of independent event channels (1..16).
REQ-002 The module SHALL have parameter CW, default 32, meaning the per-channel counter width in bits (8..32).
REQ-003 The module SHALL have parameter WW, default 16, meaning the window-length width in bits.
REQ-004 The module SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 The module SHALL have port reset_l  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port enable  input  1  run windows while high.
REQ-007 The module SHALL have port clear  input  1  synchronous clear of all state.
REQ-008 The module SHALL have port win_len  input  WW  window length in clk cycles.
REQ-009 The module SHALL have port thresh  input  CW  over-threshold compare value, shared by all channels.
REQ-010 The module SHALL have port ev  input  NCH  per-channel event strobes, one event per high cycle.
REQ-011 The module SHALL have port busy  output  1  high while a window is in progress.
REQ-012 The module SHALL have port win_count  output  WW  cycles elapsed in the current window.
REQ-013 The module SHALL have port snap_valid  output  1  one-cycle pulse when new snapshot data is valid.
REQ-014 The module SHALL have port snap_count  output  NCH*CW  final window counts, channel i at bits [i*CW +: CW].
REQ-015 The module SHALL have port over  output  NCH  per channel: snapshot count >= thresh.
REQ-016 The module SHALL have port sat  output  NCH  per channel: counter saturated during the snapshotted window.

Function
REQ-017 The control FSM SHALL have exactly two states, IDLE and RUN.
REQ-018 IDLE SHALL move to RUN when enable=1 and win_len!=0; win_len=0 SHALL keep IDLE.
REQ-019 On entry to RUN, win_len SHALL be latched; later win_len changes SHALL NOT affect the running window.
REQ-020 A window SHALL span exactly the latched win_len cycles in RUN; ev is sampled in each of those cycles, including the first and the last.
REQ-021 In each RUN cycle, every channel with ev[i]=1 SHALL increment its counter by 1.
REQ-022 A counter at 2^CW-1 SHALL hold that value (no wrap) and set its internal sat flag for the rest of the window.
REQ-023 win_count SHALL read 0 in the first RUN cycle, increase by 1 per cycle, and read 0 in IDLE.
REQ-024 busy SHALL equal (state==RUN).
REQ-025 At the last window cycle, snap_count, over and sat SHALL be loaded with values including that cycle's events, and SHALL be visible one cycle later.
REQ-026 snap_valid SHALL be high for exactly the cycle in which that new data first becomes visible.
REQ-027 over[i] SHALL be computed as an unsigned CW-bit compare against thresh sampled in the last window cycle.
REQ-028 After the last window cycle, all counters and sat flags SHALL clear.
REQ-029 If enable is still 1 after the last window cycle, the next window SHALL start the following cycle with no gap, re-latching win_len; a win_len of 0 at that point SHALL send the FSM to IDLE.
REQ-030 If enable is 0 after the last window cycle, the FSM SHALL go to IDLE.
REQ-031 enable=0 in a non-last RUN cycle SHALL abort the window: the FSM goes to IDLE next cycle, counters are discarded, and snap_valid and the snapshot are unchanged.
REQ-032 enable=0 in the last window cycle SHALL still complete that window normally.
REQ-033 clear=1 SHALL take precedence over every other input.
REQ-034 clear=1 SHALL zero all counters, snap_count, over, sat and snap_valid, and move the FSM to IDLE on the next edge.
REQ-035 Snapshot outputs SHALL hold their value until the next completed window, a clear, or a reset.

Reset
REQ-036 While reset_l=0, the FSM SHALL be IDLE and busy, win_count, snap_valid, snap_count, over, sat and all counters SHALL be 0, independent of clk.
REQ-037 Reset assertion mid-window SHALL discard the window without producing snap_valid.
REQ-038 The first RUN entry after reset release SHALL require enable=1 sampled on a clk edge with reset_l=1.

Verification
REQ-039 Scenario: NCH=4, CW=32, win_len=10, thresh=5, ev=4'b0101 held for 10 cycles, then enable low -> one snap_valid, ch0=ch2=10, ch1=ch3=0, over=4'b0101, sat=0, busy low the cycle after snap_valid.
REQ-040 Scenario: back-to-back windows, win_len=4, enable held, ev[0] high only in the last cycle of window 1 and the first cycle of window 2 -> both snapshots show ch0=1, snap_valid pulses 4 cycles apart, busy never drops.
REQ-041 Scenario: CW=8, win_len=300, ev[1] always high -> ch1=255, sat[1]=1, over[1]=1 for thresh=255, other sat bits 0.
REQ-042 Scenario: enable dropped at win_count=3 of an 8-cycle window -> no snap_valid, previous snapshot retained, busy=0 next cycle.
REQ-043 Scenario: clear pulsed mid-window, and separately reset_l pulsed low mid-window -> all outputs 0 immediately for reset and after the next edge for clear; a new window runs only when enable=1.
REQ-044 Scenario: win_len changed from 6 to 2 during a window, and win_len=0 with enable=1 -> the window still lasts 6 cycles; win_len=0 keeps the FSM IDLE.
